// File: rtl/stack_engine_if.sv
// Command and memory-bus signals of the stack engine.
// The engine takes the slave view; the host/memory side takes the master view.
interface stack_engine_if;
  logic        push;
  logic        pop;
  logic [15:0] push_data;
  logic [15:0] pop_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        underflow;
  logic [15:0] sp;
  logic        mem_req;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  push, pop, push_data, mem_rdata, mem_ack,
    output pop_data, busy, done, overflow, underflow, sp,
           mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output push, pop, push_data, mem_rdata, mem_ack,
    input  pop_data, busy, done, overflow, underflow, sp,
           mem_req, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_engine.sv
// Hardware push/pop engine for a downward-growing stack of 16-bit words
// in byte-addressed memory, with overflow/underflow rejection.
module stack_engine #(
  parameter logic [15:0] STACK_BASE  = 16'h0100,
  parameter logic [15:0] STACK_LIMIT = 16'h0080
) (
  input  logic           clock,
  input  logic           reset,
  stack_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PUSH_MEM, POP_MEM, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] pop_data_q, pop_data_d;
  logic [15:0] wdata_q, wdata_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sp_q        <= STACK_BASE;
      pop_data_q  <= 16'h0000;
      wdata_q     <= 16'h0000;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      wdata_q     <= wdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    wdata_d     = wdata_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous push and pop falls through both branches as a no-op.
        if (bus.push && !bus.pop) begin
          if (sp_q == STACK_LIMIT) begin
            overflow_d = 1'b1;
          end else begin
            wdata_d = bus.push_data;
            state_d = PUSH_MEM;
          end
        end else if (bus.pop && !bus.push) begin
          if (sp_q == STACK_BASE) begin
            underflow_d = 1'b1;
          end else begin
            state_d = POP_MEM;
          end
        end
      end
      PUSH_MEM: begin
        if (bus.mem_ack) begin
          sp_d    = sp_q - 16'd2;
          state_d = DONE;
        end
      end
      POP_MEM: begin
        if (bus.mem_ack) begin
          pop_data_d = bus.mem_rdata;
          sp_d       = sp_q + 16'd2;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops mem_req without a clock.
  assign bus.mem_req   = (state_q == PUSH_MEM) || (state_q == POP_MEM);
  assign bus.mem_write = (state_q == PUSH_MEM);
  assign bus.mem_addr  = (state_q == PUSH_MEM) ? (sp_q - 16'd2) : sp_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.sp        = sp_q;
  assign bus.pop_data  = pop_data_q;

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter STACK_BASE, default 16'h0100, meaning the empty-stack SP value and the SP reset value.
REQ-002 SHALL have parameter STACK_LIMIT, default 16'h0080, meaning the lowest legal SP (stack full).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  push request, sampled only when busy=0.
REQ-006 SHALL have port pop  input  1  pop request, sampled only when busy=0.
REQ-007 SHALL have port push_data  input  16  word to push, captured with push.
REQ-008 SHALL have port pop_data  output  16  last popped word.
REQ-009 SHALL have port busy  output  1  operation in flight; new commands ignored.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse: push rejected, stack full.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse: pop rejected, stack empty.
REQ-013 SHALL have port sp  output  16  current stack pointer, feeds the downstream SP register write port.
REQ-014 SHALL have port mem_req  output  1  memory request, held until mem_ack.
REQ-015 SHALL have port mem_write  output  1  1=write, 0=read; valid while mem_req=1.
REQ-016 SHALL have port mem_addr  output  16  byte address; valid while mem_req=1.
REQ-017 SHALL have port mem_wdata  output  16  write data; valid while mem_req=1.
REQ-018 SHALL have port mem_rdata  input  16  read data, valid in the mem_ack cycle.
REQ-019 SHALL have port mem_ack  input  1  memory completion, one cycle.

Function
REQ-020 SHALL implement states IDLE, PUSH_MEM, POP_MEM, DONE; busy=1 in every state except IDLE.
REQ-021 SHALL use a downward-growing, byte-addressed stack of 16-bit words: SP addresses the top item; SP=STACK_BASE means empty; SP=STACK_LIMIT means full.
REQ-022 SHALL, in IDLE with push=1, pop=0, and SP!=STACK_LIMIT, capture push_data and move to PUSH_MEM with mem_addr=SP-2, mem_write=1, mem_wdata=captured data.
REQ-023 SHALL, in IDLE with pop=1, push=0, and SP!=STACK_BASE, move to POP_MEM with mem_addr=SP, mem_write=0.
REQ-024 SHALL drive mem_req=1 from the first cycle in PUSH_MEM/POP_MEM and hold mem_req, mem_addr, mem_write, and mem_wdata stable until the mem_ack cycle.
REQ-025 SHALL, on mem_ack in PUSH_MEM, update SP to SP-2 and go to DONE; in POP_MEM, register mem_rdata into pop_data, update SP to SP+2, and go to DONE.
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE; SP and pop_data are already updated in the DONE cycle.
REQ-027 SHALL give a minimum latency of 3 cycles from command sample to done when mem_ack arrives in the first request cycle.
REQ-028 SHALL, for push when SP=STACK_LIMIT, pulse overflow=1 the next cycle, stay in IDLE, and leave SP and memory untouched.
REQ-029 SHALL, for pop when SP=STACK_BASE, pulse underflow=1 the next cycle, stay in IDLE, and leave SP and pop_data unchanged.
REQ-030 SHALL treat push=1 and pop=1 together in IDLE as a no-op: no state change, no flags.
REQ-031 SHALL ignore push/pop while busy=1, and ignore mem_ack outside PUSH_MEM/POP_MEM.
REQ-032 SHALL hold pop_data until the next successful pop.
REQ-033 SHALL perform 16-bit unsigned SP arithmetic; SP SHALL never leave [STACK_LIMIT, STACK_BASE].

Reset
REQ-034 SHALL, on reset=1, immediately (without a clock) force state=IDLE, SP=STACK_BASE, pop_data=0, and busy/done/overflow/underflow/mem_req/mem_write=0.
REQ-035 SHALL, on reset mid-operation, abandon the access with no SP update; a late mem_ack after reset SHALL be ignored.

Verification
REQ-036 SHALL verify: reset -> sp=16'h0100, busy=0, mem_req=0, all pulses 0.
REQ-037 SHALL verify: push 16'hBEEF, mem_ack after 2 cycles -> mem_addr=16'h00FE, mem_write=1, mem_wdata=16'hBEEF; then done pulse, sp=16'h00FE.
REQ-038 SHALL verify: then pop with mem_rdata=16'hBEEF -> mem_addr=16'h00FE, mem_write=0; then done, pop_data=16'hBEEF, sp=16'h0100.
REQ-039 SHALL verify: pop at sp=16'h0100 -> underflow one cycle, no mem_req; 64 pushes then a 65th push -> sp=16'h0080, overflow one cycle, no mem_req.
REQ-040 SHALL verify: push and pop together in IDLE -> no change; push issued while busy -> ignored, single done.
REQ-041 SHALL verify: reset asserted while mem_req=1 -> mem_req=0 without a clock edge, sp unchanged, and a following mem_ack has no effect.
